// File: rtl/fft_output_reorder.sv
// fft_output_reorder
//   Captures one N-point FFT frame that arrives in bit-reversed order and
//   replays it in natural order over a valid/ready stream. Capture is armed by
//   the rising edge of the control unit's cycle-done flag.
//   Optional build macro FFT_REORDER_SCALE_EN: outputs are divided by N
//   (arithmetic shift right by LOG2N); otherwise samples pass through unchanged.
module fft_output_reorder #(
  parameter int N      = 16,
  parameter int LOG2N  = 4,
  parameter int DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cycle_done,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_re,
  output logic signed [DATA_W-1:0] o_im,
  output logic [LOG2N-1:0]         o_index,
  output logic                     o_frame_done,
  output logic                     o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t                  state_reg, state_next;
  logic                    cycle_done_reg;
  logic                    arm;
  logic [LOG2N-1:0]        wr_cnt_reg, wr_cnt_next;
  logic [LOG2N-1:0]        rd_cnt_reg, rd_cnt_next;
  logic [LOG2N-1:0]        wr_addr;
  logic [LOG2N-1:0]        rd_addr;
  logic                    mem_we;
  logic                    out_load;
  logic                    frame_done_reg, frame_done_next;
  logic                    err_reg, err_next;
  logic [2*DATA_W-1:0]     mem [N];
  logic [2*DATA_W-1:0]     out_reg;
  logic signed [DATA_W-1:0] stored_re;
  logic signed [DATA_W-1:0] stored_im;

  assign arm = i_cycle_done & ~cycle_done_reg;

  // The write address is the arrival count with its bits mirrored.
  generate
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign wr_addr[gi] = wr_cnt_reg[LOG2N-1-gi];
    end
  endgenerate

  // Next-state, counter and control decode for the fill/drain sequence.
  always_comb begin
    state_next      = state_reg;
    wr_cnt_next     = wr_cnt_reg;
    rd_cnt_next     = rd_cnt_reg;
    frame_done_next = 1'b0;
    err_next        = err_reg;
    mem_we          = 1'b0;
    out_load        = 1'b0;
    rd_addr         = rd_cnt_reg + 1'b1;
    o_ready         = 1'b0;
    o_valid         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arm) begin
          state_next  = ST_FILL;
          wr_cnt_next = '0;
        end
      end
      ST_FILL: begin
        o_ready = 1'b1;
        if (arm) err_next = 1'b1;
        if (i_valid) begin
          mem_we = 1'b1;
          if (wr_cnt_reg == LAST_IDX) begin
            // Bin 0 was written by the first accept, so it is already readable.
            state_next  = ST_DRAIN;
            wr_cnt_next = '0;
            rd_cnt_next = '0;
            rd_addr     = '0;
            out_load    = 1'b1;
          end else begin
            wr_cnt_next = wr_cnt_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        o_valid = 1'b1;
        if (arm) err_next = 1'b1;
        if (i_ready) begin
          if (rd_cnt_reg == LAST_IDX) begin
            state_next      = ST_IDLE;
            rd_cnt_next     = '0;
            frame_done_next = 1'b1;
          end else begin
            rd_cnt_next = rd_cnt_reg + 1'b1;
            out_load    = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters, edge detector and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      cycle_done_reg <= 1'b0;
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cycle_done_reg <= i_cycle_done;
      wr_cnt_reg     <= wr_cnt_next;
      rd_cnt_reg     <= rd_cnt_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
    end
  end

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_addr] <= {i_re, i_im};
  end

  // Registered read into the output holding register; holds under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_reg <= '0;
    end else if (out_load) begin
      out_reg <= mem[rd_addr];
    end
  end

  assign stored_re = out_reg[2*DATA_W-1:DATA_W];
  assign stored_im = out_reg[DATA_W-1:0];

`ifdef FFT_REORDER_SCALE_EN
  assign o_re = stored_re >>> LOG2N;
  assign o_im = stored_im >>> LOG2N;
`else
  assign o_re = stored_re;
  assign o_im = stored_im;
`endif

  assign o_index      = rd_cnt_reg;
  assign o_frame_done = frame_done_reg;
  assign o_err        = err_reg;

endmodule
